// File: rtl/posit_pkg.sv
// Shared posit definitions: regime port width, special encodings, decoded-field bundle.
package posit_pkg;

    localparam int unsigned POSIT_N  = 8;
    localparam int unsigned POSIT_ES = 3;

    // Signed regime value k needs clog2(n) magnitude bits plus sign and overflow headroom.
    function automatic int unsigned regime_width(input int unsigned n);
        return int'($clog2(n)) + 2;
    endfunction

    localparam int unsigned POSIT_RW = regime_width(POSIT_N);
    localparam int unsigned POSIT_MW = POSIT_N - POSIT_ES + 3;

    // Special encodings, returned wide and narrowed by the caller to n bits.
    function automatic logic [63:0] posit_nar(input int unsigned n);
        return 64'(1) << (n - 1);
    endfunction

    function automatic logic [63:0] posit_maxpos(input int unsigned n);
        return posit_nar(n) - 64'(1);
    endfunction

    function automatic logic [63:0] posit_minpos(input int unsigned n);
        return 64'(n - n + 1);
    endfunction

    typedef struct packed {
        logic                zero;
        logic                nar;
        logic                sign;
        logic [POSIT_RW-1:0] regime;
        logic [POSIT_ES-1:0] exponent;
        logic [POSIT_MW-1:0] mantissa;
    } posit_fields_t;

endpackage

// File: rtl/posit_rounder.sv
// Round-to-nearest-even, saturate to minpos/maxpos, apply sign and specials.
// Ports: mag/guard/sticky (unrounded magnitude), ovf/unf (regime clamped),
//        sign/zero/nar (result flags), posit (final N-bit word, combinational).
module posit_rounder
    import posit_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [N-2:0] mag,
    input  logic         guard,
    input  logic         sticky,
    input  logic         ovf,
    input  logic         unf,
    input  logic         sign,
    input  logic         zero,
    input  logic         nar,
    output logic [N-1:0] posit
);

    localparam logic [N-1:0] NAR_W    = N'(posit_nar(N));
    localparam logic [N-1:0] MAXPOS_W = N'(posit_maxpos(N));
    localparam logic [N-1:0] MINPOS_W = N'(posit_minpos(N));

    logic         round_up;
    logic [N-1:0] sum;
    logic [N-2:0] mag_sat;
    logic [N-1:0] word;

    always_comb begin
        round_up = guard && (sticky || mag[0]);
        sum      = {1'b0, mag} + N'(round_up);
        // Carry into the sign position means the magnitude rounded past maxpos.
        if (ovf || sum[N-1]) begin
            mag_sat = MAXPOS_W[N-2:0];
        end else if (unf || (sum[N-2:0] == '0)) begin
            mag_sat = MINPOS_W[N-2:0];
        end else begin
            mag_sat = sum[N-2:0];
        end
        word = {1'b0, mag_sat};
        if (sign) begin
            word = -word;
        end
        if (nar) begin
            posit = NAR_W;
        end else if (zero) begin
            posit = '0;
        end else begin
            posit = word;
        end
    end

endmodule

// File: rtl/posit_construction.sv
// Packs decoded posit fields (sign, regime k, exponent, mantissa) into an N-bit posit.
// Two-stage valid/ready pipeline: stage 1 builds the left-justified bit string,
// stage 2 rounds/saturates/signs and holds the output word.
// Ports: clk, reset (sync, active-high), in_valid/in_ready + in_* fields,
//        out_valid/out_ready + out_posit.
module posit_construction
    import posit_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned ES = 3,
    parameter int unsigned RS = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_zero,
    input  logic            in_nar,
    input  logic            in_sign,
    input  logic [RS+1:0]   in_regime,
    input  logic [ES-1:0]   in_exponent,
    input  logic [N-ES+2:0] in_mantissa,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_posit
);

    localparam int unsigned FW   = N - ES + 2;
    localparam int unsigned SW   = 2 * N + 2;
    localparam int          KMAX = int'(N) - 2;

    // Stage 1 registers
    logic           s1_valid;
    logic [2*N-1:0] s1_frame;
    logic           s1_sticky;
    logic           s1_ovf;
    logic           s1_unf;
    logic           s1_sign;
    logic           s1_zero;
    logic           s1_nar;

    // Pack-stage combinational values
    int             k_val;
    int             k_clamp;
    int             reg_len;
    logic [N-1:0]   reg_bits;
    logic [SW-1:0]  bit_str;
    logic           pk_ovf;
    logic           pk_unf;

    logic           in_fire;
    logic           s1_move;
    logic [N-1:0]   rnd_posit;

    // Hidden bit is implied by the regime/exponent encoding and never stored.
    logic           unused_hidden;
    assign unused_hidden = in_mantissa[N-ES+2];

    assign in_ready = !s1_valid || !out_valid || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign s1_move  = s1_valid && (!out_valid || out_ready);

    // Regime run-length encode, then left-justify the whole string.
    always_comb begin
        k_val   = int'($signed(in_regime));
        pk_ovf  = k_val > KMAX;
        pk_unf  = k_val < -KMAX;
        k_clamp = pk_ovf ? KMAX : (pk_unf ? -KMAX : k_val);
        if (k_clamp >= 0) begin
            reg_len  = k_clamp + 2;
            reg_bits = N'(((64'(1) << (k_clamp + 1)) - 64'(1)) << 1);
        end else begin
            reg_len  = 1 - k_clamp;
            reg_bits = N'(1);
        end
        // Regime sits right-justified in an N-bit slot; shifting by the unused
        // slot width puts its first bit at the MSB.
        bit_str = {reg_bits, in_exponent, in_mantissa[FW-1:0]} << (int'(N) - reg_len);
    end

    posit_rounder #(.N(N)) u_rounder (
        .mag    (s1_frame[2*N-1:N+1]),
        .guard  (s1_frame[N]),
        .sticky ((|s1_frame[N-1:0]) | s1_sticky),
        .ovf    (s1_ovf),
        .unf    (s1_unf),
        .sign   (s1_sign),
        .zero   (s1_zero),
        .nar    (s1_nar),
        .posit  (rnd_posit)
    );

    // Pipeline registers; data moves only on a handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_frame  <= '0;
            s1_sticky <= 1'b0;
            s1_ovf    <= 1'b0;
            s1_unf    <= 1'b0;
            s1_sign   <= 1'b0;
            s1_zero   <= 1'b0;
            s1_nar    <= 1'b0;
            out_valid <= 1'b0;
            out_posit <= '0;
        end else begin
            if (in_fire) begin
                s1_valid  <= 1'b1;
                s1_frame  <= bit_str[SW-1:2];
                s1_sticky <= |bit_str[1:0];
                s1_ovf    <= pk_ovf;
                s1_unf    <= pk_unf;
                s1_sign   <= in_sign;
                s1_zero   <= in_zero;
                s1_nar    <= in_nar;
            end else if (s1_move) begin
                s1_valid  <= 1'b0;
            end

            if (s1_move) begin
                out_valid <= 1'b1;
                out_posit <= rnd_posit;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_posit_construction.sv
// Scoreboard bench for posit_construction (N=8, ES=3) with directed vectors.
module tb_posit_construction;
    import posit_pkg::*;

    localparam int unsigned N  = POSIT_N;
    localparam int unsigned ES = POSIT_ES;

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic                in_zero;
    logic                in_nar;
    logic                in_sign;
    logic [POSIT_RW-1:0] in_regime;
    logic [ES-1:0]       in_exponent;
    logic [POSIT_MW-1:0] in_mantissa;
    logic                out_valid;
    logic                out_ready;
    logic [N-1:0]        out_posit;

    logic [N-1:0] sb_q[$];
    int checks   = 0;
    int errors   = 0;
    int accepted = 0;

    always #5 clk = ~clk;

    posit_construction #(.N(N), .ES(ES)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_zero    (in_zero),
        .in_nar     (in_nar),
        .in_sign    (in_sign),
        .in_regime  (in_regime),
        .in_exponent(in_exponent),
        .in_mantissa(in_mantissa),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_posit  (out_posit)
    );

    function automatic posit_fields_t mk(input logic z, input logic n, input logic s,
                                         input int k, input int e, input int m);
        posit_fields_t f;
        f.zero     = z;
        f.nar      = n;
        f.sign     = s;
        f.regime   = POSIT_RW'(k);
        f.exponent = ES'(e);
        f.mantissa = POSIT_MW'(m);
        return f;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Drive one input and record its expected result when the handshake is seen.
    task automatic send(input posit_fields_t f, input logic [N-1:0] exp_posit);
        int  waited = 0;
        bit  done   = 1'b0;
        in_zero     = f.zero;
        in_nar      = f.nar;
        in_sign     = f.sign;
        in_regime   = f.regime;
        in_exponent = f.exponent;
        in_mantissa = f.mantissa;
        in_valid    = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back(exp_posit);
                accepted++;
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 100) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout: in_ready stuck low, expected %0h pending", exp_posit);
                    in_valid = 1'b0;
                    return;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb_q.size()), 32'd0);
    endtask

    // Monitor: every output transfer is compared against the scoreboard head.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %0h, expected no output", out_posit);
            end else begin
                logic [N-1:0] e;
                e = sb_q.pop_front();
                if (out_posit !== e) begin
                    errors++;
                    $display("FAIL out_posit: got %0h, expected %0h", out_posit, e);
                end
            end
        end
    end

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_zero     = 1'b0;
        in_nar      = 1'b0;
        in_sign     = 1'b0;
        in_regime   = '0;
        in_exponent = '0;
        in_mantissa = '0;
        out_ready   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_posit", 32'(out_posit), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Directed vectors: zero, nar, sign, k, e, mantissa -> expected
        send(mk(0, 0, 0,  0, 0, 'h80), 8'h40);
        send(mk(0, 0, 1,  0, 0, 'h80), 8'hC0);
        send(mk(0, 0, 0,  0, 0, 'hB0), 8'h42);
        send(mk(0, 0, 0,  0, 0, 'h90), 8'h40);
        send(mk(0, 0, 0,  0, 0, 'h91), 8'h41);
        send(mk(0, 0, 1,  0, 0, 'hB0), 8'hBE);
        send(mk(0, 0, 0, -1, 5, 'h80), 8'h34);
        send(mk(0, 0, 0, -3, 0, 'h80), 8'h08);
        send(mk(0, 0, 0,  2, 3, 'hC0), 8'h74);
        send(mk(0, 0, 0,  5, 3, 'h80), 8'h7E);
        send(mk(0, 0, 0,  5, 4, 'h80), 8'h7E);
        send(mk(0, 0, 0,  5, 5, 'h80), 8'h7F);
        send(mk(0, 0, 0, -6, 4, 'h80), 8'h02);
        send(mk(0, 0, 0,  6, 7, 'h80), 8'h7F);
        send(mk(0, 0, 0,  7, 0, 'h80), 8'h7F);
        send(mk(0, 0, 0, -7, 0, 'h80), 8'h01);
        send(mk(0, 0, 1, -7, 0, 'h80), 8'hFF);
        send(mk(0, 1, 0,  0, 0, 'h80), 8'h80);
        send(mk(1, 0, 0,  0, 0, 'h80), 8'h00);
        send(mk(1, 1, 1,  3, 2, 'hA5), 8'h80);
        wait_drain();

        // Backpressure: output stalled while four inputs are offered.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        accepted  = 0;
        fork
            begin
                send(mk(0, 0, 0,  0, 0, 'h80), 8'h40);
                send(mk(0, 0, 0,  0, 0, 'hB0), 8'h42);
                send(mk(0, 0, 0,  2, 3, 'hC0), 8'h74);
                send(mk(0, 0, 0, -3, 0, 'h80), 8'h08);
            end
            begin
                repeat (2) @(posedge clk);
                repeat (4) begin
                    @(negedge clk);
                    check("bp_in_ready_low", 32'(in_ready), 32'd0);
                    check("bp_out_hold", 32'(out_posit), 32'h40);
                end
                check("bp_accepted", 32'(accepted), 32'd2);
                check("bp_out_valid", 32'(out_valid), 32'd1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();
        check("bp_total_accepted", 32'(accepted), 32'd4);

        // Reset with two items in flight: both must be discarded.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(mk(0, 0, 0, 0, 0, 'h80), 8'h40);
        send(mk(0, 0, 1, 0, 0, 'h80), 8'hC0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_posit", 32'(out_posit), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        sb_q.delete();
        @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        send(mk(0, 0, 0, -1, 5, 'h80), 8'h34);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
